// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the FMRT Mini Core pipeline sequencer: data widths,
// exception codes and the exception FSM state encoding.
package pipe_ctrl_pkg;

   localparam int unsigned WORD_DATA_W = 32;
   localparam int unsigned EXP_CODE_W  = 3;

   localparam logic [EXP_CODE_W-1:0] EXP_NO_EXP     = 3'd0;
   localparam logic [EXP_CODE_W-1:0] EXP_EXT_INT    = 3'd1;
   localparam logic [EXP_CODE_W-1:0] EXP_UNDEF_INSN = 3'd2;
   localparam logic [EXP_CODE_W-1:0] EXP_OVERFLOW   = 3'd3;
   localparam logic [EXP_CODE_W-1:0] EXP_MISS_ALIGN = 3'd4;
   localparam logic [EXP_CODE_W-1:0] EXP_TRAP       = 3'd5;
   localparam logic [EXP_CODE_W-1:0] EXP_PRV_VIO    = 3'd6;
   localparam logic [EXP_CODE_W-1:0] EXP_BUS_TMO    = 3'd7;

   typedef enum logic [1:0] {
      PC_ST_RUN     = 2'd0,
      PC_ST_DRAIN   = 2'd1,
      PC_ST_HANDLER = 2'd2,
      PC_ST_HALT    = 2'd3
   } pc_st_e;

endpackage

// File: rtl/pipe_ctrl_wdt.sv
// Bus watchdog: counts consecutive busy cycles and pulses timeout once the
// count reaches LIMIT while still busy. Only built with PIPE_CTRL_WDT_EN.
module pipe_wdt #(
   parameter int unsigned LIMIT = 255
) (
   input  logic clk,
   input  logic reset,
   input  logic busy,
   output logic timeout
);

   localparam logic [7:0] LimitC = 8'(LIMIT);

   logic [7:0] cnt_q, cnt_d;

   assign timeout = busy && (cnt_q == LimitC);

   // Saturation is implicit: reaching LimitC while busy is the timeout, which clears.
   always_comb begin
      cnt_d = cnt_q;
      if (!busy || timeout) cnt_d = '0;
      else                  cnt_d = cnt_q + 8'd1;
   end

   always_ff @(posedge clk) begin
      if (reset) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: stall/flush/redirect control plus exception FSM.
// Optional bus watchdog enabled by defining PIPE_CTRL_WDT_EN.
module pipe_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int unsigned WDT_LIMIT = 255
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   if_busy,
   input  logic                   ld_hazard,
   input  logic                   br_taken,
   input  logic [WORD_DATA_W-1:0] br_addr,
   input  logic                   mem_busy,
   input  logic                   mem_en,
   input  logic [EXP_CODE_W-1:0]  mem_exp_code,
   input  logic [WORD_DATA_W-1:0] mem_pc,
   input  logic                   mem_eret,
   input  logic [WORD_DATA_W-1:0] trap_vec,
   output logic                   pc_stall,
   output logic                   if_stall,
   output logic                   id_stall,
   output logic                   ex_stall,
   output logic                   mem_stall,
   output logic                   if_flush,
   output logic                   id_flush,
   output logic                   ex_flush,
   output logic                   mem_flush,
   output logic                   redirect,
   output logic [WORD_DATA_W-1:0] new_pc,
   output logic [WORD_DATA_W-1:0] epc,
   output logic [EXP_CODE_W-1:0]  exp_cause,
   output logic [1:0]             ctrl_st
);

   pc_st_e                 st_q, st_d, st_eff;
   logic [WORD_DATA_W-1:0] epc_q, epc_d;
   logic [EXP_CODE_W-1:0]  cause_q, cause_d;
   logic                   wdt_tmo;
   logic                   exc;

`ifdef PIPE_CTRL_WDT_EN
   pipe_wdt #(.LIMIT(WDT_LIMIT)) u_wdt (
      .clk     (clk),
      .reset   (reset),
      .busy    (mem_busy),
      .timeout (wdt_tmo)
   );
`else
   localparam int unsigned WDT_LIMIT_UNUSED = WDT_LIMIT;
   assign wdt_tmo = 1'b0;
`endif

   assign exc    = mem_en && (mem_exp_code != EXP_NO_EXP);
   // Outputs behave as in RUN while reset is held, whatever the stored state.
   assign st_eff = reset ? PC_ST_RUN : st_q;

   always_comb begin
      {pc_stall, if_stall, id_stall, ex_stall, mem_stall} = '0;
      {if_flush, id_flush, ex_flush, mem_flush}           = '0;
      redirect = 1'b0;
      new_pc   = '0;
      st_d     = st_q;
      epc_d    = epc_q;
      cause_d  = cause_q;
      if (st_eff == PC_ST_HALT) begin
         {pc_stall, if_stall, id_stall, ex_stall, mem_stall} = '1;
      end else if (st_eff == PC_ST_DRAIN) begin
         {if_flush, id_flush, ex_flush, mem_flush} = '1;
         st_d = PC_ST_HANDLER;
      end else if (wdt_tmo || (exc && !mem_busy)) begin
         if (st_eff == PC_ST_RUN) begin
            {if_flush, id_flush, ex_flush, mem_flush} = '1;
            redirect = 1'b1;
            new_pc   = trap_vec;
            st_d     = PC_ST_DRAIN;
            epc_d    = mem_pc;
            cause_d  = wdt_tmo ? EXP_BUS_TMO : mem_exp_code;
         end else begin
            st_d = PC_ST_HALT;
         end
      end else if (mem_busy) begin
         {pc_stall, if_stall, id_stall, ex_stall, mem_stall} = '1;
      end else if (mem_en && mem_eret && (st_eff == PC_ST_HANDLER)) begin
         {if_flush, id_flush, ex_flush, mem_flush} = '1;
         redirect = 1'b1;
         new_pc   = epc_q;
         st_d     = PC_ST_RUN;
      end else if (br_taken) begin
         {if_flush, id_flush} = '1;
         redirect = 1'b1;
         new_pc   = br_addr;
      end else if (ld_hazard) begin
         {pc_stall, if_stall, id_flush} = '1;
      end else if (if_busy) begin
         {pc_stall, if_flush} = '1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         st_q    <= PC_ST_RUN;
         epc_q   <= '0;
         cause_q <= EXP_NO_EXP;
      end else begin
         st_q    <= st_d;
         epc_q   <= epc_d;
         cause_q <= cause_d;
      end
   end

   assign epc       = epc_q;
   assign exp_cause = cause_q;
   assign ctrl_st   = st_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed vectors with literal expectations
// plus a per-cycle comparison against a behavioural model.
module tb_pipe_ctrl;

   localparam int unsigned WLIM = 4;
`ifdef PIPE_CTRL_WDT_EN
   localparam bit WDT_ON = 1'b1;
`else
   localparam bit WDT_ON = 1'b0;
`endif

   // vector order: pc_stall if_stall id_stall ex_stall mem_stall if_flush id_flush ex_flush mem_flush redirect
   localparam logic [9:0] V_NONE  = 10'b00000_0000_0;
   localparam logic [9:0] V_LD    = 10'b11000_0100_0;
   localparam logic [9:0] V_IFB   = 10'b10000_1000_0;
   localparam logic [9:0] V_BR    = 10'b00000_1100_1;
   localparam logic [9:0] V_TRAP  = 10'b00000_1111_1;
   localparam logic [9:0] V_DRAIN = 10'b00000_1111_0;
   localparam logic [9:0] V_STALL = 10'b11111_0000_0;

   logic        clk = 1'b0;
   logic        reset, if_busy, ld_hazard, br_taken, mem_busy, mem_en, mem_eret;
   logic [31:0] br_addr, mem_pc, trap_vec;
   logic [2:0]  mem_exp_code;
   logic        pc_stall, if_stall, id_stall, ex_stall, mem_stall;
   logic        if_flush, id_flush, ex_flush, mem_flush, redirect;
   logic [31:0] new_pc, epc;
   logic [2:0]  exp_cause;
   logic [1:0]  ctrl_st;
   logic [9:0]  dv;

   int n_chk  = 0;
   int n_fail = 0;

   pipe_ctrl #(.WDT_LIMIT(WLIM)) dut (
      .clk(clk), .reset(reset), .if_busy(if_busy), .ld_hazard(ld_hazard),
      .br_taken(br_taken), .br_addr(br_addr), .mem_busy(mem_busy), .mem_en(mem_en),
      .mem_exp_code(mem_exp_code), .mem_pc(mem_pc), .mem_eret(mem_eret),
      .trap_vec(trap_vec), .pc_stall(pc_stall), .if_stall(if_stall),
      .id_stall(id_stall), .ex_stall(ex_stall), .mem_stall(mem_stall),
      .if_flush(if_flush), .id_flush(id_flush), .ex_flush(ex_flush),
      .mem_flush(mem_flush), .redirect(redirect), .new_pc(new_pc), .epc(epc),
      .exp_cause(exp_cause), .ctrl_st(ctrl_st)
   );

   assign dv = {pc_stall, if_stall, id_stall, ex_stall, mem_stall,
                if_flush, id_flush, ex_flush, mem_flush, redirect};

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // mode: 0 running, 1 draining, 2 in handler, 3 halted
   int          m_st    = 0;
   logic [31:0] m_epc   = '0;
   logic [2:0]  m_cause = '0;
   int          m_busy_run = 0;
   bit          m_valid = 1'b0;

   function automatic bit m_tmo();
      return WDT_ON && mem_busy && (m_busy_run == WLIM);
   endfunction

   function automatic bit m_exc();
      return mem_en && (mem_exp_code != 3'd0) && !mem_busy;
   endfunction

   // Expected control word: decide which pipeline action applies, then map it.
   task automatic m_expect(output logic [9:0] v, output logic [31:0] pc);
      int mode;
      mode = reset ? 0 : m_st;
      v = V_NONE; pc = '0;
      if (mode == 3)                          v = V_STALL;
      else if (mode == 1)                     v = V_DRAIN;
      else if (m_tmo() || m_exc()) begin
         if (mode == 0) begin v = V_TRAP; pc = trap_vec; end
      end
      else if (mem_busy)                      v = V_STALL;
      else if (mode == 2 && mem_en && mem_eret) begin v = V_TRAP; pc = m_epc; end
      else if (br_taken)                      begin v = V_BR; pc = br_addr; end
      else if (ld_hazard)                     v = V_LD;
      else if (if_busy)                       v = V_IFB;
   endtask

   always @(posedge clk) begin
      bit tmo, ex;
      tmo = m_tmo();
      ex  = m_exc();
      if (reset) begin
         m_st = 0; m_epc = '0; m_cause = '0; m_busy_run = 0; m_valid = 1'b1;
      end else begin
         if (mem_busy && !tmo) m_busy_run = m_busy_run + 1;
         else                  m_busy_run = 0;
         if (m_st == 1) m_st = 2;
         else if (m_st != 3 && (tmo || ex)) begin
            if (m_st == 0) begin
               m_st = 1; m_epc = mem_pc; m_cause = tmo ? 3'd7 : mem_exp_code;
            end else m_st = 3;
         end else if (m_st == 2 && !mem_busy && mem_en && mem_eret) m_st = 0;
      end
   end

   always @(negedge clk) begin
      logic [9:0]  ev;
      logic [31:0] epc_exp;
      if (m_valid) begin
         m_expect(ev, epc_exp);
         chk("model_ctl",    {22'd0, dv, new_pc}, {22'd0, ev, epc_exp});
         chk("model_state",  64'(ctrl_st),   64'(m_st));
         chk("model_epc",    64'(epc),       64'(m_epc));
         chk("model_cause",  64'(exp_cause), 64'(m_cause));
      end
   end

   // ---------------- stimulus ----------------
   task automatic clr();
      reset = 0; if_busy = 0; ld_hazard = 0; br_taken = 0; mem_busy = 0;
      mem_en = 0; mem_eret = 0; mem_exp_code = 0;
      br_addr = '0; mem_pc = '0; trap_vec = 32'h80;
   endtask

   task automatic nxt();
      @(posedge clk); #1;
   endtask

   task automatic smp();
      @(negedge clk);
   endtask

   initial begin
      clr(); reset = 1;
      nxt(); nxt(); reset = 0;
      smp();
      chk("rst_state", 64'(ctrl_st), 64'd0);
      chk("rst_epc",   64'(epc), 64'd0);
      chk("rst_cause", 64'(exp_cause), 64'd0);
      chk("rst_ctl",   64'(dv), 64'(V_NONE));

      nxt(); ld_hazard = 1; smp();
      chk("ld_ctl", 64'(dv), 64'(V_LD));
      chk("ld_state", 64'(ctrl_st), 64'd0);
      nxt(); clr(); if_busy = 1; smp();
      chk("ifbusy_ctl", 64'(dv), 64'(V_IFB));
      nxt(); clr(); br_taken = 1; br_addr = 32'h200; if_busy = 1; smp();
      chk("br_ctl", 64'(dv), 64'(V_BR));
      chk("br_pc",  64'(new_pc), 64'h200);

      // trap entry
      nxt(); clr(); mem_en = 1; mem_exp_code = 3; mem_pc = 32'h104; smp();
      chk("trap_ctl", 64'(dv), 64'(V_TRAP));
      chk("trap_pc",  64'(new_pc), 64'h80);
      nxt(); clr(); ld_hazard = 1; smp();
      chk("drain_state", 64'(ctrl_st), 64'd1);
      chk("drain_epc",   64'(epc), 64'h104);
      chk("drain_cause", 64'(exp_cause), 64'd3);
      chk("drain_ctl",   64'(dv), 64'(V_DRAIN));
      nxt(); clr(); smp();
      chk("handler_state", 64'(ctrl_st), 64'd2);

      // exception return, then the same pulse in RUN
      nxt(); mem_en = 1; mem_eret = 1; smp();
      chk("eret_ctl", 64'(dv), 64'(V_TRAP));
      chk("eret_pc",  64'(new_pc), 64'h104);
      nxt(); smp();
      chk("eret_state", 64'(ctrl_st), 64'd0);
      chk("eret_run_ctl", 64'(dv), 64'(V_NONE));

      // busy vs exception vs branch
      nxt(); clr(); mem_busy = 1; mem_en = 1; mem_exp_code = 5; mem_pc = 32'h300;
      br_taken = 1; br_addr = 32'h400; smp();
      chk("busy_ctl", 64'(dv), 64'(V_STALL));
      nxt(); smp();
      chk("busy2_ctl", 64'(dv), 64'(V_STALL));
      nxt(); mem_busy = 0; smp();
      chk("busy_trap_ctl", 64'(dv), 64'(V_TRAP));
      chk("busy_trap_pc",  64'(new_pc), 64'h80);
      nxt(); clr(); smp();
      chk("busy_trap_epc",   64'(epc), 64'h300);
      chk("busy_trap_cause", 64'(exp_cause), 64'd5);

      // double fault
      nxt(); mem_en = 1; mem_exp_code = 2; smp();
      chk("dfault_ctl", 64'(dv), 64'(V_NONE));
      nxt(); clr();
      for (int i = 0; i < 12; i++) begin
         ld_hazard = i[0]; br_taken = i[1]; smp();
         chk("halt_state", 64'(ctrl_st), 64'd3);
         chk("halt_ctl",   64'(dv), 64'(V_STALL));
         nxt();
      end
      clr(); reset = 1; smp();
      chk("halt_rst_ctl", 64'(dv), 64'(V_NONE));
      nxt(); reset = 0; smp();
      chk("halt_rst_state", 64'(ctrl_st), 64'd0);
      chk("halt_rst_epc",   64'(epc), 64'd0);

      // eret beats branch; exception beats eret
      nxt(); mem_en = 1; mem_exp_code = 4; mem_pc = 32'h500;
      nxt(); clr(); nxt(); mem_en = 1; mem_eret = 1; br_taken = 1; br_addr = 32'h900; smp();
      chk("eret_br_pc", 64'(new_pc), 64'h500);
      nxt(); clr(); mem_en = 1; mem_eret = 1; mem_exp_code = 1; mem_pc = 32'h600; smp();
      chk("exc_eret_pc", 64'(new_pc), 64'h80);
      nxt(); clr(); smp();
      chk("exc_eret_cause", 64'(exp_cause), 64'd1);
      nxt(); mem_en = 1; mem_eret = 1; mem_exp_code = 6; smp();
      chk("exc_eret_h_ctl", 64'(dv), 64'(V_NONE));
      nxt(); clr(); smp();
      chk("exc_eret_h_state", 64'(ctrl_st), 64'd3);
      reset = 1; nxt(); reset = 0;

`ifdef PIPE_CTRL_WDT_EN
      mem_busy = 1; mem_pc = 32'h700;
      for (int i = 0; i < 4; i++) begin
         smp(); chk("wdt_stall", 64'(dv), 64'(V_STALL)); nxt();
      end
      smp();
      chk("wdt_trap_ctl", 64'(dv), 64'(V_TRAP));
      chk("wdt_trap_pc",  64'(new_pc), 64'h80);
      nxt(); smp();
      chk("wdt_cause", 64'(exp_cause), 64'd7);
      chk("wdt_epc",   64'(epc), 64'h700);
      chk("wdt_state", 64'(ctrl_st), 64'd1);
      nxt(); clr(); reset = 1; nxt(); reset = 0;
`endif

      // randomised traffic checked by the model
      for (int i = 0; i < 400; i++) begin
         reset        = ($urandom_range(0, 39) == 0);
         if_busy      = ($urandom_range(0, 3) == 0);
         ld_hazard    = ($urandom_range(0, 3) == 0);
         br_taken     = ($urandom_range(0, 3) == 0);
         br_addr      = $urandom;
         mem_busy     = ($urandom_range(0, 4) == 0) || (mem_busy && $urandom_range(0, 3) != 0);
         mem_en       = $urandom_range(0, 1) == 1;
         mem_exp_code = ($urandom_range(0, 5) == 0) ? 3'($urandom_range(1, 6)) : 3'd0;
         mem_eret     = ($urandom_range(0, 5) == 0);
         mem_pc       = $urandom;
         trap_vec     = $urandom;
         nxt();
      end
      smp();
      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Pipeline sequencer for the FMRT Mini Core. It turns hazard, busy, branch and exception signals from the stages into per-register `stall`/`flush` controls for the four pipeline registers: IF/ID (`if_reg`), ID/EX (`id_reg`), EX/MEM (`ex_reg`) and MEM/WB (`mem_reg`). It also drives PC redirects and owns the exception state machine (trap entry, handler, return, double-fault halt), keeping the exception PC and cause registers. It sits beside the datapath and feeds every pipeline register's `stall`/`flush` pair.

## Interface
Parameters:
- `WDT_LIMIT`, default 255: consecutive `mem_busy` cycles before a bus-timeout exception. Used only with `PIPE_CTRL_WDT_EN`.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `if_busy`  in  1  instruction fetch not ready.
- `ld_hazard`  in  1  load-use hazard detected in ID.
- `br_taken`  in  1  taken branch/jump resolved in EX.
- `br_addr`  in  `WORD_DATA_W`  branch target.
- `mem_busy`  in  1  MEM stage access outstanding.
- `mem_en`  in  1  MEM-stage instruction valid.
- `mem_exp_code`  in  `EXP_CODE_W`  exception code in MEM.
- `mem_pc`  in  `WORD_DATA_W`  PC of the MEM-stage instruction.
- `mem_eret`  in  1  exception return in MEM (qualified by `mem_en`).
- `trap_vec`  in  `WORD_DATA_W`  handler entry address.
- `pc_stall`  out  1  hold the PC.
- `if_stall`, `id_stall`, `ex_stall`, `mem_stall`  out  1 each  pipeline register stalls.
- `if_flush`, `id_flush`, `ex_flush`, `mem_flush`  out  1 each  pipeline register flushes.
- `redirect`  out  1  load `new_pc` into the PC this cycle.
- `new_pc`  out  `WORD_DATA_W`  redirect target.
- `epc`  out  `WORD_DATA_W`  saved exception PC.
- `exp_cause`  out  `EXP_CODE_W`  saved exception code.
- `ctrl_st`  out  2  FSM state.

## Operation
- The FSM has four states: RUN, DRAIN, HANDLER and HALT.
- An exception is taken when `exc = mem_en && mem_exp_code != EXP_NO_EXP`.
- The control outputs are combinational. Priority, highest first:
  1. **HALT:** all stalls are 1, all flushes are 0, `redirect` is 0.
  2. **`mem_busy`:** `pc_stall` and all four stalls are 1. No flush or redirect.
  3. **`exc`:**
     - In RUN: all four flushes are 1, `redirect`=1 and `new_pc`=`trap_vec`. On the next edge, `epc`<=`mem_pc`, `exp_cause`<=`mem_exp_code`, and the FSM goes to DRAIN.
     - In HANDLER (double fault): no flush, and the FSM goes to HALT.
  4. **`mem_eret` in HANDLER:** `if_flush`, `id_flush`, `ex_flush` and `mem_flush` are 1, `redirect`=1 and `new_pc`=`epc`. The FSM goes to RUN. `mem_eret` in any other state is ignored.
  5. **`br_taken`:** `if_flush` and `id_flush` are 1, `redirect`=1 and `new_pc`=`br_addr`.
  6. **`ld_hazard`:** `pc_stall` and `if_stall` are 1, and `id_flush`=1 (inserts a bubble into EX).
  7. **`if_busy`:** `pc_stall`=1 and `if_flush`=1 (inserts a bubble into ID).
- DRAIN lasts one cycle. All flushes are 1, no redirect, and all inputs are ignored. The FSM then goes to HANDLER.
- HANDLER applies the normal RUN rules, except for the double-fault and eret handling in rows 3 and 4.
- A stall and a flush are never asserted together on the same register.
- When no row applies, all outputs are 0 and `new_pc`=0.

## Timing
- Reset values: FSM in RUN, `epc`=0, `exp_cause`=`EXP_NO_EXP`, watchdog count 0, `ctrl_st`=RUN.
- During reset the outputs follow the RUN rules with the current inputs. The datapath reset dominates.
- Stall, flush, redirect and `new_pc` have zero latency: they are combinational from the inputs in the same cycle.
- `epc`, `exp_cause` and `ctrl_st` update on the edge after trap entry. They are therefore valid in the first DRAIN cycle.
- Trap entry to first handler fetch: the redirect cycle, then 1 DRAIN cycle.
- An exception together with `mem_busy` is deferred until `mem_busy` falls.
- An exception together with `br_taken` or `mem_eret`: the exception wins.
- `mem_eret` together with `br_taken`: `mem_eret` wins.
- Reset in any state, including HALT, returns the FSM to RUN on the next edge.

## Configuration
- `PIPE_CTRL_WDT_EN` defined:
  - An 8-bit counter increments on each cycle with `mem_busy`=1 and clears when `mem_busy`=0. It saturates at `WDT_LIMIT`.
  - When count==`WDT_LIMIT` and `mem_busy`=1, a synthetic exception with code `EXP_BUS_TMO` is taken. It uses the trap-entry rules of row 3, except that it overrides the `mem_busy` stall. The counter clears on the next edge.
  - The synthetic exception is also subject to the double-fault rule in HANDLER.
- `PIPE_CTRL_WDT_EN` undefined:
  - No counter is built, and `mem_busy` stalls indefinitely.
  - `WDT_LIMIT` is unused.

## Structure
- The state encodings (`PC_ST_RUN`=0, `PC_ST_DRAIN`=1, `PC_ST_HANDLER`=2, `PC_ST_HALT`=3) and `EXP_BUS_TMO` go in a new shared defines header, `pipe_ctrl.h`. They sit next to `EXP_NO_EXP` and the other exception codes.
- The watchdog is one natural sub-module, `pipe_wdt`. It takes `clk`, `reset` and `busy` and produces a `timeout` pulse, and is instantiated only under `PIPE_CTRL_WDT_EN`.

## Test plan
- **Load-use hazard:** `ld_hazard`=1 for 1 cycle in RUN → `pc_stall`=`if_stall`=`id_flush`=1, all other outputs 0, `ctrl_st` stays 0.
- **Trap entry:** `mem_en`=1, `mem_exp_code`=3, `mem_pc`=0x0000_0104, `trap_vec`=0x0000_0080 → same cycle all flushes are 1 and `new_pc`=0x80. Next cycle `epc`=0x104, `exp_cause`=3, `ctrl_st`=DRAIN. The cycle after, `ctrl_st`=HANDLER.
- **Exception return:** `mem_eret`=1 in HANDLER with `epc`=0x104 → `redirect`=1, `new_pc`=0x104, and `ctrl_st` is RUN next cycle. The same `mem_eret` pulse in RUN → no redirect.
- **Busy vs. exception vs. branch:** `mem_busy`=1 with an exception and `br_taken` → all stalls 1 and no redirect. When `mem_busy` drops, the trap is taken, not the branch.
- **Double fault:** exception in HANDLER → `ctrl_st`=HALT and stalls stuck at 1 for 10+ cycles. `reset`=1 for 1 cycle → `ctrl_st`=RUN, `epc`=0.
- **Watchdog (with `PIPE_CTRL_WDT_EN`, `WDT_LIMIT`=4):** `mem_busy` held high → cycles 0–3 are stalled, cycle 4 takes the trap with `exp_cause`=`EXP_BUS_TMO`.
